seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 clk  input  1  the single clock; every register updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operands and mode are valid.
REQ-005 in_ready  output  1  block can accept a new operation.
REQ-006 A  input  WIDTH  multiplicand.
REQ-007 B  input  WIDTH  multiplier.
REQ-008 is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 out_valid  output  1  hi/lo hold a completed product.
REQ-010 out_ready  input  1  consumer accepts the product.
REQ-011 hi  output  WIDTH  upper half of the 2*WIDTH product.
REQ-012 lo  output  WIDTH  lower half of the 2*WIDTH product.

Function
REQ-013 The block SHALL use a state machine with states IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 On an edge with in_valid=1 in IDLE, the block SHALL latch A, B and is_signed, clear the accumulator and iteration counter, and enter BUSY.
REQ-016 BUSY SHALL run one shift-add step per cycle, consuming one multiplier bit LSB-first, for exactly WIDTH cycles.
REQ-017 On the WIDTH-th BUSY edge, the block SHALL enter DONE with the final product registered, so out_valid rises WIDTH+1 edges after the accepting edge.
REQ-018 hi and lo SHALL hold stable in DONE until an edge with out_ready=1, after which the block SHALL return to IDLE.
REQ-019 hi and lo SHALL read zero in IDLE and BUSY.
REQ-020 Unsigned mode SHALL produce the exact unsigned 2*WIDTH product {hi,lo}=A*B.
REQ-021 Signed mode SHALL produce the exact two's-complement 2*WIDTH product, including the most-negative-by-most-negative case.
REQ-022 Signed products SHALL be formed by multiplying magnitudes and conditionally negating the 2*WIDTH result on entry to DONE.
REQ-023 in_valid in BUSY or DONE SHALL be ignored, and operands SHALL NOT be sampled.
REQ-024 A DONE->IDLE handoff SHALL take one cycle, so the next operation cannot be accepted on the edge that drains the previous result.
REQ-025 Operand changes after acceptance SHALL NOT affect the result in progress.

Reset
REQ-026 rst=1 on any edge SHALL force IDLE, zero the counter, accumulator and latched operands, and drive in_ready=1, out_valid=0, hi=0 and lo=0 on the following cycle.
REQ-027 Reset in BUSY or DONE SHALL discard the operation with no output.
REQ-028 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-029 Macro SEQ_MULT_SIGNED_EN SHALL gate signed support.
REQ-030 With SEQ_MULT_SIGNED_EN defined, is_signed SHALL select the mode per REQ-021.
REQ-031 Without SEQ_MULT_SIGNED_EN, is_signed SHALL be ignored, all operations SHALL be unsigned, and no magnitude or negation logic SHALL be synthesised.
REQ-032 Latency SHALL be identical in both builds.

Structure
REQ-033 Shared package mult_pkg SHALL hold the state enum typedef (IDLE/BUSY/DONE) and the default-width constant MULT_WIDTH_DEFAULT=16.
REQ-034 Counter width SHALL be derived as $clog2(WIDTH+1).
REQ-035 One sub-module, mult_step, SHALL implement the combinational single-iteration add-and-shift (accumulator, multiplicand, multiplier bit -> next accumulator), instantiated once.

Verification (WIDTH=16)
REQ-036 Unsigned A=0xFFFF, B=0xFFFF -> hi=0xFFFE, lo=0x0001, with out_valid at edge 17 after accept.
REQ-037 Signed A=0xFFFD (-3), B=0x0005 -> hi=0xFFFF, lo=0xFFF1; signed A=B=0x8000 -> hi=0x4000, lo=0x0000.
REQ-038 Unsigned A=0x8000, B=0x8000 -> hi=0x4000, lo=0x0000; same operands with is_signed=1 in a build without the macro -> identical result.
REQ-039 Hold out_ready=0 for 10 cycles in DONE while toggling A/B/in_valid -> hi/lo stable, in_ready=0, exactly one result delivered after out_ready=1.
REQ-040 Assert rst at BUSY cycle 8 of A=0x1234, B=0x5678 -> next cycle IDLE, out_valid=0, hi=lo=0; a new A=0x0003, B=0x0007 -> lo=0x0015, hi=0.
REQ-041 Back-to-back stream of 100 random operations with random out_ready stalls -> every product matches a reference model, in order, with none dropped or duplicated.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential multiplier.
package mult_pkg;

   localparam int unsigned MULT_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/seq_mult_step.sv
// One shift-add iteration: add the multiplicand into the upper half when the
// multiplier bit is set, then shift the whole accumulator right by one.
module mult_step #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   mcand,
   input  logic               mbit,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mbit ? {1'b0, mcand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
   end

endmodule

// File: rtl/seq_mult.sv
// Sequential WIDTH x WIDTH multiplier, one multiplier bit per cycle.
// Signed operation is compiled in only when SEQ_MULT_SIGNED_EN is defined.
module seq_mult
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   mult_state_t        state, state_next;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] step_out;
   logic [2*WIDTH-1:0] final_acc;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               last;

`ifdef SEQ_MULT_SIGNED_EN
   logic neg_d;
   logic neg_q;

   // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
   always_comb begin
      a_mag     = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
      b_mag     = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
      neg_d     = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      final_acc = neg_q ? (~step_out + 1'b1) : step_out;
   end

   always_ff @(posedge clk) begin
      if (rst)
         neg_q <= 1'b0;
      else if (state == IDLE && in_valid)
         neg_q <= neg_d;
   end
`else
   logic unused_is_signed;

   always_comb begin
      a_mag            = A;
      b_mag            = B;
      final_acc        = step_out;
      unused_is_signed = is_signed;
   end
`endif

   mult_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .mcand    (mcand),
      .mbit     (mplier[0]),
      .acc_next (step_out)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = BUSY;
         BUSY:    if (last)      state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      hi        = '0;
      lo        = '0;
      if (state == DONE) begin
         hi = acc[2*WIDTH-1:WIDTH];
         lo = acc[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            BUSY: begin
               acc    <= last ? final_acc : step_out;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult.sv
// Directed and randomised checks for seq_mult at WIDTH=16.
// Signed expectations follow SEQ_MULT_SIGNED_EN, matching the RTL build.
module tb_seq_mult;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        is_signed;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] hi;
   logic [15:0] lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mult #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      logic signed [31:0] sp;
      logic        [31:0] up;
      sa = a;
      sb = b;
      sp = sa * sb;
      up = {16'h0, a} * {16'h0, b};
`ifdef SEQ_MULT_SIGNED_EN
      return s ? sp : up;
`else
      return up;
`endif
   endfunction

   // Submit one operation, wait for the result, stall, then drain it.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int stall, output logic [31:0] res, output int edges);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {63'h0, in_ready}, 64'h1);
      A = a; B = b; is_signed = s; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; A = ~a; B = $urandom; is_signed = ~s;
      edges = 1;
      chk("busy_in_ready", {63'h0, in_ready}, 64'h0);
      chk("busy_out_zero", {32'h0, hi, lo}, 64'h0);
      while (!out_valid && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      chk("done_reached", {63'h0, out_valid}, 64'h1);
      for (int i = 0; i < stall; i++) @(negedge clk);
      res = {hi, lo};
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_out_valid", {63'h0, out_valid}, 64'h0);
      chk("drain_in_ready", {63'h0, in_ready}, 64'h1);
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] held;
      logic [15:0] ra, rb;
      logic        rs;
      int          edges;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; is_signed = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_in_ready", {63'h0, in_ready}, 64'h1);
      chk("reset_out_valid", {63'h0, out_valid}, 64'h0);
      chk("reset_hilo", {32'h0, hi, lo}, 64'h0);

      // Latency counted with the accepting edge as edge 1.
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, res, edges);
      chk("ffff_sq", {32'h0, res}, 64'hFFFE_0001);
      chk("ffff_latency", 64'(edges), 64'd17);

      run_op(16'hFFFD, 16'h0005, 1'b1, 1, res, edges);
`ifdef SEQ_MULT_SIGNED_EN
      chk("neg3_x5", {32'h0, res}, 64'hFFFF_FFF1);
`else
      chk("neg3_x5", {32'h0, res}, 64'h0004_FFF1);
`endif
      chk("neg3_latency", 64'(edges), 64'd17);

      run_op(16'h8000, 16'h8000, 1'b1, 0, res, edges);
      chk("minneg_sq_s", {32'h0, res}, 64'h4000_0000);
      run_op(16'h8000, 16'h8000, 1'b0, 0, res, edges);
      chk("minneg_sq_u", {32'h0, res}, 64'h4000_0000);

      // Hold in DONE while inputs wiggle, then drain with in_valid high.
      A = 16'h1234; B = 16'h0010; is_signed = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      chk("hold_done", {63'h0, out_valid}, 64'h1);
      held = {hi, lo};
      chk("hold_value", {32'h0, held}, 64'h0001_2340);
      for (int i = 0; i < 10; i++) begin
         A = $urandom; B = $urandom; in_valid = i[0];
         @(negedge clk);
         chk("hold_stable", {32'h0, hi, lo}, {32'h0, held});
         chk("hold_in_ready", {63'h0, in_ready}, 64'h0);
      end
      A = 16'h0002; B = 16'h0003; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      chk("handoff_idle", {63'h0, in_ready}, 64'h1);
      chk("handoff_no_valid", {63'h0, out_valid}, 64'h0);
      repeat (20) @(negedge clk);
      chk("no_duplicate", {63'h0, out_valid}, 64'h0);

      // Reset in the middle of an operation.
      A = 16'h1234; B = 16'h5678; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("midrst_in_ready", {63'h0, in_ready}, 64'h1);
      chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("midrst_hilo", {32'h0, hi, lo}, 64'h0);
      repeat (20) @(negedge clk);
      chk("midrst_discard", {63'h0, out_valid}, 64'h0);
      run_op(16'h0003, 16'h0007, 1'b0, 0, res, edges);
      chk("after_rst_3x7", {32'h0, res}, 64'h0000_0015);

      for (int k = 0; k < 100; k++) begin
         ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
         if (k == 0) begin ra = 16'h7FFF; rb = 16'h8000; rs = 1'b1; end
         run_op(ra, rb, rs, $urandom_range(0, 3), res, edges);
         chk("rand_product", {32'h0, res}, {32'h0, model(ra, rb, rs)});
         chk("rand_latency", 64'(edges), 64'd17);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
